// File: rtl/dft_result_collector.sv
// Per-bin DFT result FIFO streaming to the AXI read path; optional MAG_SQ_EN squares {re,im} into magnitude^2.
// Strobe-to-o_RVALID is 1 cycle (2 with MAG_SQ_EN); head beat holds while i_RREADY is low, strobes are dropped when full.
module dft_result_collector #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 12
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    i_clear,
  input  logic [IDX_WIDTH-1:0]    i_samp_number,
  input  logic                    i_bin_valid,
  input  logic [IDX_WIDTH-1:0]    i_bin_index,
  input  logic [DATA_WIDTH-1:0]   i_bin_data,
  output logic [DATA_WIDTH-1:0]   o_RDATA,
  output logic                    o_RVALID,
  input  logic                    i_RREADY,
  output logic                    o_RLAST,
  output logic                    o_calc_end,
  output logic                    o_overflow,
  output logic [$clog2(DEPTH):0]  o_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                 state;
  entry_t                 mem [DEPTH];
  entry_t                 head;
  entry_t                 mem_wdat;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          mem_waddr;
  logic                   mem_we;
  logic [IDX_WIDTH-1:0]   n_reg;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   strobe_last;
  logic                   pipe_next;
  logic [LW-1:0]          level_next;
  logic                   rvalid_next;

  assign head        = mem[rd_ptr];
  assign full        = (o_level == FULL_LEVEL);
  assign pop         = o_RVALID & i_RREADY;
  assign strobe_last = (i_bin_index == n_reg - IDX_WIDTH'(1));
  // A full FIFO still takes a strobe when the head leaves in the same cycle.
  assign push        = i_bin_valid && (state == COLLECT) && (!full || pop);
  assign level_next  = o_level + LW'(push) - LW'(pop);
  // A word still in the squaring stage is counted in o_level but is not yet visible.
  assign rvalid_next = (level_next != LW'(pipe_next));

  assign o_RDATA = o_RVALID ? head.data : '0;
  assign o_RLAST = o_RVALID & head.last;

`ifdef MAG_SQ_EN
  logic signed [15:0] re;
  logic signed [15:0] im;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;
  logic [31:0]        mag;
  logic               pipe_vld;
  entry_t             pipe_entry;
  logic [PW-1:0]      pipe_ptr;

  assign re    = i_bin_data[31:16];
  assign im    = i_bin_data[15:0];
  assign re_sq = 32'(re) * 32'(re);
  assign im_sq = 32'(im) * 32'(im);
  // Each square is at most 2^30, so the unsigned sum cannot wrap.
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  always_ff @(posedge clk) begin
    if (Reset || i_clear) begin
      pipe_vld <= 1'b0;
    end else begin
      pipe_vld <= push;
    end
    if (push) begin
      pipe_entry <= '{last: strobe_last, data: DATA_WIDTH'(mag)};
      pipe_ptr   <= wr_ptr;
    end
  end

  assign pipe_next = push;
  assign mem_we    = pipe_vld;
  assign mem_waddr = pipe_ptr;
  assign mem_wdat  = pipe_entry;
`else
  assign pipe_next = 1'b0;
  assign mem_we    = push;
  assign mem_waddr = wr_ptr;
  assign mem_wdat  = '{last: strobe_last, data: i_bin_data};
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset || i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_RVALID   <= 1'b0;
      o_calc_end <= 1'b0;
      o_overflow <= 1'b0;
      if (Reset) begin
        state <= IDLE;
        n_reg <= '0;
      end else begin
        state <= COLLECT;
        n_reg <= i_samp_number;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      o_level    <= level_next;
      o_RVALID   <= rvalid_next;
      o_calc_end <= pop && head.last && (state == DRAIN);
      if (i_bin_valid && (state == COLLECT) && full && !pop) begin
        o_overflow <= 1'b1;
      end
      case (state)
        COLLECT: if (push && strobe_last) state <= DRAIN;
        DRAIN:   if (pop && head.last)    state <= DONE;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_result_collector.sv
// Scoreboard bench for dft_result_collector: expected beats queued at strobe time, checked on each transfer.
module tb_dft_result_collector;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int IW    = 12;
`ifdef MAG_SQ_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk = 1'b0;
  logic                   Reset = 1'b1;
  logic                   i_clear = 1'b0;
  logic [IW-1:0]          i_samp_number = '0;
  logic                   i_bin_valid = 1'b0;
  logic [IW-1:0]          i_bin_index = '0;
  logic [DW-1:0]          i_bin_data = '0;
  logic                   i_RREADY = 1'b0;
  logic [DW-1:0]          o_RDATA;
  logic                   o_RVALID;
  logic                   o_RLAST;
  logic                   o_calc_end;
  logic                   o_overflow;
  logic [$clog2(DEPTH):0] o_level;

  dft_result_collector #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .Reset(Reset), .i_clear(i_clear), .i_samp_number(i_samp_number),
    .i_bin_valid(i_bin_valid), .i_bin_index(i_bin_index), .i_bin_data(i_bin_data),
    .o_RDATA(o_RDATA), .o_RVALID(o_RVALID), .i_RREADY(i_RREADY), .o_RLAST(o_RLAST),
    .o_calc_end(o_calc_end), .o_overflow(o_overflow), .o_level(o_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] expq[$];

  logic                   obs_vld, obs_last, obs_calc, obs_ovf, obs_xfer;
  logic [DW-1:0]          obs_data;
  logic [$clog2(DEPTH):0] obs_level;

  function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef MAG_SQ_EN
    longint re;
    longint im;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    return 32'(re * re + im * im);
`else
    return d;
`endif
  endfunction

  // Outputs are registered, so sampling at the falling edge sees the state left by the last rising edge.
  task automatic sample();
    @(negedge clk);
    obs_vld   = o_RVALID;
    obs_last  = o_RLAST;
    obs_data  = o_RDATA;
    obs_calc  = o_calc_end;
    obs_ovf   = o_overflow;
    obs_level = o_level;
  endtask

  task automatic drive(input logic bv, input logic [IW-1:0] idx, input logic [DW-1:0] dat,
                       input logic rdy, input logic rst, input logic clr, input logic [IW-1:0] n);
    i_bin_valid   = bv;
    i_bin_index   = idx;
    i_bin_data    = dat;
    i_RREADY      = rdy;
    Reset         = rst;
    i_clear       = clr;
    i_samp_number = n;
    obs_xfer      = obs_vld && rdy;
  endtask

  task automatic cyc(input logic bv, input logic [IW-1:0] idx, input logic [DW-1:0] dat,
                     input logic rdy, input logic rst, input logic clr, input logic [IW-1:0] n);
    sample();
    drive(bv, idx, dat, rdy, rst, clr, n);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_vld !== 1'b0)   begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", obs_vld); end
    n_cmp++; if (obs_level !== '0)   begin n_bad++; $display("FAIL reset_level: got %0d want 0", obs_level); end
    n_cmp++; if (obs_data !== '0)    begin n_bad++; $display("FAIL reset_rdata: got %h want 0", obs_data); end
    n_cmp++; if ({obs_last, obs_calc, obs_ovf} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got last/calc/ovf=%b want 000", {obs_last, obs_calc, obs_ovf});
    end
    cyc(0, 0, 0, 0, 0, 1, 20);
    for (int i = 0; i < 5; i++) cyc(1, IW'(i), 32'hA000_0000 + i, 0, 0, 0, 0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_level !== 5)    begin n_bad++; $display("FAIL mid_level: got %0d want 5", obs_level); end
    n_cmp++; if (obs_vld !== 1'b1)   begin n_bad++; $display("FAIL mid_rvalid: got %b want 1", obs_vld); end
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(1, 3, 32'h1234_5678, 1, 0, 0, 0);
    n_cmp++; if ({obs_vld, obs_last, obs_calc, obs_ovf, obs_level, obs_data} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: got vld=%b lvl=%0d data=%h want all 0", obs_vld, obs_level, obs_data);
    end
    cyc(1, 19, 32'h1111_1111, 1, 0, 0, 0);
    // Reset and clear together: reset wins, so the block lands in IDLE and ignores strobes.
    cyc(0, 0, 0, 0, 1, 1, 4);
    cyc(1, 0, 32'h2222_2222, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if ({obs_vld, obs_level} !== '0) begin
      n_bad++; $display("FAIL idle_ignores: got vld=%b lvl=%0d want 0/0", obs_vld, obs_level);
    end
  endtask

  task automatic test_basic();
    int first_vld, last_at, calc_at, n_last, n_calc;
    logic [32:0] e;
    logic        bv;
    logic [31:0] d;
    expq.delete();
    first_vld = -1; last_at = -1; calc_at = -1; n_last = 0; n_calc = 0;
    cyc(0, 0, 0, 1, 0, 1, 4);
    for (int c = 0; c < 20; c++) begin
      bv = (c < 4);
      d  = 32'h0001_0002 + 32'h0001_0001 * c;
      cyc(bv, IW'(c), d, 1, 0, 0, 0);
      if (bv) expq.push_back({c == 3, exp_word(d)});
      if (obs_vld && first_vld < 0) first_vld = c;
      if (obs_calc) begin
        n_calc++; calc_at = c;
        n_cmp++; if (obs_vld !== 1'b0) begin n_bad++; $display("FAIL basic_calc_vs_rvalid: rvalid=%b want 0", obs_vld); end
      end
      if (obs_xfer) begin
        if (obs_last) begin n_last++; last_at = c; end
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL basic_beat: unexpected beat %h", obs_data); end
        else begin
          e = expq.pop_front();
          if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL basic_beat: got %h want %h", {obs_last, obs_data}, e); end
        end
      end
    end
    n_cmp++; if (first_vld !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", first_vld, LAT); end
    n_cmp++; if (n_last !== 1)      begin n_bad++; $display("FAIL basic_rlast_count: got %0d want 1", n_last); end
    n_cmp++; if (n_calc !== 1)      begin n_bad++; $display("FAIL basic_calc_count: got %0d want 1", n_calc); end
    n_cmp++; if (calc_at !== last_at + 1) begin n_bad++; $display("FAIL basic_calc_timing: got %0d want %0d", calc_at, last_at + 1); end
    n_cmp++; if (expq.size() !== 0) begin n_bad++; $display("FAIL basic_leftover: got %0d want 0", expq.size()); end
    // DONE must ignore further strobes.
    cyc(1, 0, 32'h5555_5555, 1, 0, 0, 0);
    cyc(1, 3, 32'h6666_6666, 1, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if ({obs_vld, obs_level} !== '0) begin n_bad++; $display("FAIL done_ignores: got vld=%b lvl=%0d want 0/0", obs_vld, obs_level); end
  endtask

  task automatic test_overflow();
    int n_last, n_calc;
    logic [32:0] e;
    logic [31:0] d;
    expq.delete();
    n_last = 0; n_calc = 0;
    cyc(0, 0, 0, 0, 0, 1, 20);
    for (int c = 0; c < 20; c++) begin
      d = 32'h1000_0000 + c;
      cyc(1, IW'(c), d, 0, 0, 0, 0);
      if (c < DEPTH) expq.push_back({1'b0, exp_word(d)});
    end
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs_level !== DEPTH) begin n_bad++; $display("FAIL ovf_level: got %0d want %0d", obs_level, DEPTH); end
    n_cmp++; if (obs_ovf !== 1'b1)    begin n_bad++; $display("FAIL ovf_flag: got %b want 1", obs_ovf); end
    for (int c = 0; c < 30; c++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      if (obs_calc) n_calc++;
      if (obs_xfer) begin
        if (obs_last) n_last++;
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL ovf_beat: unexpected beat %h", obs_data); end
        else begin
          e = expq.pop_front();
          if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL ovf_beat: got %h want %h", {obs_last, obs_data}, e); end
        end
      end
    end
    n_cmp++; if (n_last !== 0)       begin n_bad++; $display("FAIL ovf_rlast: got %0d want 0", n_last); end
    n_cmp++; if (n_calc !== 0)       begin n_bad++; $display("FAIL ovf_calc: got %0d want 0", n_calc); end
    n_cmp++; if (expq.size() !== 0)  begin n_bad++; $display("FAIL ovf_leftover: got %0d want 0", expq.size()); end
    n_cmp++; if (obs_ovf !== 1'b1)   begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", obs_ovf); end
  endtask

  task automatic test_full_wrap();
    int n_last, n_calc;
    logic [32:0] e;
    logic [31:0] d;
    expq.delete();
    n_last = 0; n_calc = 0;
    cyc(0, 0, 0, 0, 0, 1, 64);
    for (int c = 0; c < DEPTH; c++) begin
      d = 32'h0300_0000 + c * 32'h0000_0101;
      cyc(1, IW'(c), d, 0, 0, 0, 0);
      expq.push_back({1'b0, exp_word(d)});
    end
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Three full laps of simultaneous push and pop while the FIFO stays full.
    for (int c = DEPTH; c < 64; c++) begin
      d = 32'h0300_0000 + c * 32'h0000_0101;
      cyc(1, IW'(c), d, 1, 0, 0, 0);
      expq.push_back({c == 63, exp_word(d)});
      n_cmp++; if (obs_level !== DEPTH) begin n_bad++; $display("FAIL wrap_level: bin %0d got %0d want %0d", c, obs_level, DEPTH); end
      if (obs_xfer) begin
        if (obs_last) n_last++;
        n_cmp++;
        e = expq.pop_front();
        if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL wrap_beat: got %h want %h", {obs_last, obs_data}, e); end
      end else begin
        n_cmp++; n_bad++; $display("FAIL wrap_stall: got no transfer want transfer at bin %0d", c);
      end
    end
    for (int c = 0; c < 24; c++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      if (obs_calc) n_calc++;
      if (obs_xfer) begin
        if (obs_last) n_last++;
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL wrap_beat: unexpected beat %h", obs_data); end
        else begin
          e = expq.pop_front();
          if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL wrap_beat: got %h want %h", {obs_last, obs_data}, e); end
        end
      end
    end
    n_cmp++; if (obs_ovf !== 1'b0)  begin n_bad++; $display("FAIL wrap_ovf: got %b want 0", obs_ovf); end
    n_cmp++; if (n_last !== 1)      begin n_bad++; $display("FAIL wrap_rlast: got %0d want 1", n_last); end
    n_cmp++; if (n_calc !== 1)      begin n_bad++; $display("FAIL wrap_calc: got %0d want 1", n_calc); end
    n_cmp++; if (expq.size() !== 0) begin n_bad++; $display("FAIL wrap_leftover: got %0d want 0", expq.size()); end
  endtask

  task automatic test_random();
    int          next_bin, n_last, n_calc;
    bit          done;
    logic        prev_stall, bv, rdy;
    logic [32:0] prev_beat, e;
    logic [31:0] d;
    expq.delete();
    next_bin = 0; n_last = 0; n_calc = 0; done = 0; prev_stall = 0; prev_beat = '0;
    cyc(0, 0, 0, 0, 0, 1, 64);
    for (int c = 0; c < 3000 && !done; c++) begin
      sample();
      if (prev_stall) begin
        n_cmp++;
        if (!obs_vld || {obs_last, obs_data} !== prev_beat) begin
          n_bad++; $display("FAIL rand_stable: got vld=%b %h want 1 %h", obs_vld, {obs_last, obs_data}, prev_beat);
        end
      end
      bv  = (next_bin < 64) && (obs_level < DEPTH) && ($urandom_range(0, 3) != 0);
      d   = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      drive(bv, IW'(next_bin), d, rdy, 0, 0, 0);
      if (bv) begin expq.push_back({next_bin == 63, exp_word(d)}); next_bin++; end
      if (obs_calc) begin n_calc++; done = 1; end
      if (obs_xfer) begin
        if (obs_last) n_last++;
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL rand_beat: unexpected beat %h", obs_data); end
        else begin
          e = expq.pop_front();
          if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL rand_beat: got %h want %h", {obs_last, obs_data}, e); end
        end
      end
      prev_stall = obs_vld && !rdy;
      prev_beat  = {obs_last, obs_data};
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rand_timeout: got no calc_end want one within 3000 cycles"); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      if (obs_calc) n_calc++;
      if (obs_xfer) begin n_cmp++; n_bad++; $display("FAIL rand_extra_beat: got %h want none", obs_data); end
    end
    n_cmp++; if (n_last !== 1)      begin n_bad++; $display("FAIL rand_rlast: got %0d want 1", n_last); end
    n_cmp++; if (n_calc !== 1)      begin n_bad++; $display("FAIL rand_calc: got %0d want 1", n_calc); end
    n_cmp++; if (expq.size() !== 0) begin n_bad++; $display("FAIL rand_leftover: got %0d want 0", expq.size()); end
  endtask

`ifdef MAG_SQ_EN
  task automatic test_mag();
    int          first_vld;
    logic [32:0] e;
    expq.delete();
    first_vld = -1;
    cyc(0, 0, 0, 1, 0, 1, 2);
    expq.push_back({1'b0, 32'h8000_0000});
    expq.push_back({1'b1, 32'd25});
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      cyc(1, 0, 32'h8000_8000, 1, 0, 0, 0);
      else if (c == 1) cyc(1, 1, 32'h0003_FFFC, 1, 0, 0, 0);
      else             cyc(0, 0, 0, 1, 0, 0, 0);
      if (obs_vld && first_vld < 0) first_vld = c;
      if (obs_xfer) begin
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL mag_beat: unexpected beat %h", obs_data); end
        else begin
          e = expq.pop_front();
          if ({obs_last, obs_data} !== e) begin n_bad++; $display("FAIL mag_beat: got %h want %h", {obs_last, obs_data}, e); end
        end
      end
    end
    n_cmp++; if (first_vld !== 2)   begin n_bad++; $display("FAIL mag_latency: got %0d want 2", first_vld); end
    n_cmp++; if (expq.size() !== 0) begin n_bad++; $display("FAIL mag_leftover: got %0d want 0", expq.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_wrap();
    test_random();
`ifdef MAG_SQ_EN
    test_mag();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
